// File: rtl/msg_queue_if.sv
// Handshake bundle between msg_parser, msg_queue and the message consumer.
// The master side drives the parser inputs and out_ready; the slave side is the queue.
interface msg_queue_if #(
    parameter int MAX_MSG_BYTES = 32,
    parameter int DEPTH         = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                         in_valid;
    logic [15:0]                  in_length;
    logic [8*MAX_MSG_BYTES-1:0]   in_data;
    logic                         in_error;
    logic                         out_valid;
    logic                         out_ready;
    logic [15:0]                  out_length;
    logic [8*MAX_MSG_BYTES-1:0]   out_data;
    logic [LW-1:0]                level;
    logic [15:0]                  drop_err;
    logic [15:0]                  drop_ovf;
    logic                         overflow;

    modport master (
        output in_valid, in_length, in_data, in_error, out_ready,
        input  out_valid, out_length, out_data, level, drop_err, drop_ovf, overflow
    );

    modport slave (
        input  in_valid, in_length, in_data, in_error, out_ready,
        output out_valid, out_length, out_data, level, drop_err, drop_ovf, overflow
    );
endinterface

// File: rtl/msg_queue.sv
// Message queue: absorbs bursts from msg_parser (no backpressure upstream), drops
// errored / illegal-length / overflow messages, and presents a show-ahead head entry.
module msg_queue #(
    parameter int MAX_MSG_BYTES = 32,
    parameter int DEPTH         = 4
) (
    input logic        clk,
    input logic        rst,
    msg_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int DW = 8 * MAX_MSG_BYTES;

    logic [DW-1:0] r_data_mem [DEPTH];
    logic [15:0]   r_len_mem  [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [15:0]   r_drop_err;
    logic [15:0]   r_drop_ovf;
    logic          r_overflow;

    logic          w_len_ok;
    logic          w_legal;
    logic          w_illegal;
    logic          w_nonempty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf_drop;
    logic [DW-1:0] w_masked;

    assign w_len_ok   = (bus.in_length != 16'd0) && (bus.in_length <= 16'(MAX_MSG_BYTES));
    assign w_legal    = bus.in_valid && !bus.in_error && w_len_ok;
    assign w_illegal  = bus.in_valid && !w_legal;
    assign w_nonempty = (r_level != '0);
    assign w_full     = (r_level == LW'(DEPTH));
    // A pop only counts when there is a head entry, so ready on an empty queue is ignored.
    assign w_pop      = w_nonempty && bus.out_ready;
    // A pop in the same cycle frees a slot, so a full queue still accepts the push.
    assign w_push     = w_legal && (!w_full || w_pop);
    assign w_ovf_drop = w_legal && w_full && !w_pop;

    // Zero payload bytes at and beyond the message length before storing.
    always_comb begin
        // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
        w_masked = '0;
        for (int k = 0; k < MAX_MSG_BYTES; k++) begin
            if (16'(k) < bus.in_length) begin
                w_masked[8*k +: 8] = bus.in_data[8*k +: 8];
            end
        end
    end

    // Entry storage write port.
    // NOTE: storage has no reset; level/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= w_masked;
            r_len_mem[r_wr_ptr]  <= bus.in_length;
        end
    end

    // Pointer and occupancy tracking; power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for all registered state.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Saturating drop counters and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_err <= '0;
            r_drop_ovf <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_illegal && (r_drop_err != 16'hFFFF)) begin
                r_drop_err <= r_drop_err + 16'd1;
            end
            if (w_ovf_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_ovf != 16'hFFFF) begin
                    r_drop_ovf <= r_drop_ovf + 16'd1;
                end
            end
        end
    end

    // Show-ahead head: outputs come straight from the entry at rd_ptr, zero when empty.
    assign bus.out_valid  = w_nonempty;
    assign bus.out_length = w_nonempty ? r_len_mem[r_rd_ptr]  : 16'd0;
    assign bus.out_data   = w_nonempty ? r_data_mem[r_rd_ptr] : '0;
    assign bus.level      = r_level;
    assign bus.drop_err   = r_drop_err;
    assign bus.drop_ovf   = r_drop_ovf;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_msg_queue.sv
// Self-checking bench for msg_queue: directed steps plus a randomized stream,
// compared against a queue-based reference model of the message buffer.
module tb_msg_queue;
    localparam int MAXB  = 32;
    localparam int DEPTH = 4;
    localparam int DW    = 8 * MAXB;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [15:0]   len;
        logic [DW-1:0] data;
    } ent_t;

    logic clk;
    logic rst;

    msg_queue_if #(.MAX_MSG_BYTES(MAXB), .DEPTH(DEPTH)) bus ();

    msg_queue #(.MAX_MSG_BYTES(MAXB), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    ent_t q[$];
    int   m_drop_err;
    int   m_drop_ovf;
    bit   m_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mask_payload(input logic [15:0] len, input logic [DW-1:0] d);
        logic [DW-1:0] m;
        m = {DW{1'b1}};
        m = m >> (8 * (MAXB - int'(len)));
        return d & m;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_drop_err = 0;
        m_drop_ovf = 0;
        m_overflow = 1'b0;
    endtask

    // Compare every observable output against the model.
    task automatic check_all(input string tag);
        logic [15:0]   e_len;
        logic [DW-1:0] e_data;
        e_len  = (q.size() != 0) ? q[0].len  : 16'd0;
        e_data = (q.size() != 0) ? q[0].data : '0;
        check({tag, ".out_valid"},  DW'(bus.out_valid),  DW'(q.size() != 0));
        check({tag, ".out_length"}, DW'(bus.out_length), DW'(e_len));
        check({tag, ".out_data"},   bus.out_data,        e_data);
        check({tag, ".level"},      DW'(bus.level),      DW'(q.size()));
        check({tag, ".drop_err"},   DW'(bus.drop_err),   DW'(m_drop_err));
        check({tag, ".drop_ovf"},   DW'(bus.drop_ovf),   DW'(m_drop_ovf));
        check({tag, ".overflow"},   DW'(bus.overflow),   DW'(m_overflow));
    endtask

    // One clock cycle: drive at negedge, advance the model, compare #1 after posedge.
    task automatic step(input string tag, input logic v, input logic [15:0] len,
                        input logic [DW-1:0] data, input logic err, input logic rdy);
        bit pop, legal, full;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_length = len;
        bus.in_data   = data;
        bus.in_error  = err;
        bus.out_ready = rdy;
        pop   = (q.size() != 0) && rdy;
        legal = v && !err && (len >= 1) && (len <= MAXB);
        full  = (q.size() == DEPTH);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (legal) begin
            if (!full || pop) q.push_back('{len: len, data: mask_payload(len, data)});
            else begin
                m_drop_ovf = sat_inc(m_drop_ovf);
                m_overflow = 1'b1;
            end
        end else if (v) begin
            m_drop_err = sat_inc(m_drop_err);
        end
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic rdy);
        step(tag, 1'b0, 16'd0, '0, 1'b0, rdy);
    endtask

    initial begin
        logic [DW-1:0] d;
        int            sent;
        int            cyc;
        bit            v;

        // Reset state
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_length = '0;
        bus.in_data   = '0;
        bus.in_error  = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("reset_release");

        // 1. Short message masks the upper bytes; appears one cycle after the push
        d = rand_data();
        d[47:0] = 48'hAABBCC_DDEEFF;
        step("t1_push", 1'b1, 16'd3, d, 1'b0, 1'b0);
        check("t1_data", bus.out_data, 256'hDDEEFF);
        check("t1_len", DW'(bus.out_length), DW'(16'd3));
        check("t1_level", DW'(bus.level), DW'(1));
        idle("t1_pop", 1'b1);

        // 2. Fill, overflow on the fifth, then drain in order
        for (int i = 0; i < 4; i++) step("t2_fill", 1'b1, 16'(5 + i), rand_data(), 1'b0, 1'b0);
        step("t2_ovf", 1'b1, 16'd9, rand_data(), 1'b0, 1'b0);
        check("t2_level_full", DW'(bus.level), DW'(4));
        check("t2_drop_ovf", DW'(bus.drop_ovf), DW'(16'd1));
        check("t2_overflow", DW'(bus.overflow), DW'(1'b1));
        idle("t2_hold", 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t2_order", DW'(bus.out_length), DW'(16'(5 + i)));
            idle("t2_drain", 1'b1);
        end
        check("t2_empty_valid", DW'(bus.out_valid), DW'(1'b0));

        // 3. Full queue with a simultaneous pop and push
        for (int i = 0; i < 4; i++) step("t3_fill", 1'b1, 16'(10 + i), rand_data(), 1'b0, 1'b0);
        step("t3_pushpop", 1'b1, 16'd14, rand_data(), 1'b0, 1'b1);
        check("t3_level", DW'(bus.level), DW'(4));
        check("t3_drop_ovf", DW'(bus.drop_ovf), DW'(16'd1));
        for (int i = 0; i < 4; i++) begin
            check("t3_order", DW'(bus.out_length), DW'(16'(11 + i)));
            idle("t3_drain", 1'b1);
        end

        // 4. Illegal messages are dropped; ready on an empty queue does nothing
        step("t4_err", 1'b1, 16'd5, rand_data(), 1'b1, 1'b1);
        check("t4_valid_a", DW'(bus.out_valid), DW'(1'b0));
        step("t4_len0", 1'b1, 16'd0, rand_data(), 1'b0, 1'b0);
        check("t4_valid_b", DW'(bus.out_valid), DW'(1'b0));
        step("t4_len33", 1'b1, 16'(MAXB + 1), rand_data(), 1'b0, 1'b1);
        check("t4_valid_c", DW'(bus.out_valid), DW'(1'b0));
        check("t4_drop_err", DW'(bus.drop_err), DW'(16'd3));
        check("t4_level", DW'(bus.level), DW'(0));
        // Full-length message keeps every byte
        d = rand_data();
        step("t4_full_len", 1'b1, 16'(MAXB), d, 1'b0, 1'b0);
        check("t4_full_data", bus.out_data, d);
        idle("t4_pop", 1'b1);

        // 5. Random stream of 10 legal messages with random ready
        sent = 0;
        cyc  = 0;
        while (!(sent == 10 && q.size() == 0) && cyc < 300) begin
            v = (sent < 10) && ($urandom_range(0, 1) == 1);
            step("t5_stream", v, 16'($urandom_range(1, MAXB)), rand_data(), 1'b0,
                 (sent == 10) ? 1'b1 : 1'($urandom_range(0, 1)));
            if (v) sent++;
            cyc++;
        end
        check("t5_completed", DW'(sent == 10 && q.size() == 0), DW'(1'b1));

        // Saturation of drop_err
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_error  = 1'b1;
            bus.in_length = 16'd4;
            bus.out_ready = 1'b0;
            @(posedge clk);
            m_drop_err = sat_inc(m_drop_err);
        end
        #1;
        check("sat_drop_err", DW'(bus.drop_err), DW'(16'hFFFF));
        check_all("sat");

        // 6. Async reset with entries stored
        for (int i = 0; i < 3; i++) step("t6_fill", 1'b1, 16'(20 + i), rand_data(), 1'b0, 1'b0);
        check("t6_level3", DW'(bus.level), DW'(3));
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_valid_now", DW'(bus.out_valid), DW'(1'b0));
        check_all("t6_in_reset");
        @(negedge clk);
        rst = 1'b0;
        d = rand_data();
        step("t6_new_push", 1'b1, 16'd7, d, 1'b0, 1'b0);
        check("t6_head_len", DW'(bus.out_length), DW'(16'd7));
        check("t6_head_level", DW'(bus.level), DW'(1));
        idle("t6_pop", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
